// File: rtl/mem_port.sv
// Multicycle memory port: turns decoder strobes into one registered valid/ready access and
// holds the instruction and memory data registers. Optional abort on a stuck access: MEM_PORT_TIMEOUT_EN.
module mem_port #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] wd,
  input  logic              IorD,
  input  logic              IRwrite,
  input  logic              memwrite,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] data,
  output logic              stall,
  output logic              err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic   req;
  logic   start;
  logic   capture;
  logic   abort;
  logic   is_fetch;

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

  assign req   = IorD | IRwrite;
  assign start = (state == IDLE) && req;
  assign stall = !reset && (start || (state == BUSY));

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             expired;

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  // Counts unanswered BUSY cycles; the cycle that hits TIMEOUT is the last BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (state == BUSY && !mem_ready)
        cnt <= cnt + CNT_W'(1);
      if (abort)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = BUSY;
      BUSY: begin
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
`ifdef MEM_PORT_TIMEOUT_EN
        else if (expired) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request register: latched once in IDLE, held unchanged for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_fetch  <= 1'b0;
    end else if (start) begin
      mem_valid <= 1'b1;
      mem_we    <= IorD & memwrite;
      mem_addr  <= word_align(IorD ? aluout : pc);
      mem_wdata <= wd;
      is_fetch  <= !IorD;
    end else if (capture || abort) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // A timed-out access loads zero so stale data cannot be mistaken for a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= '0;
      data  <= '0;
    end else if (capture || abort) begin
      if (is_fetch)
        instr <= abort ? '0 : mem_rdata;
      else if (!mem_we)
        data  <= abort ? '0 : mem_rdata;
    end
  end

endmodule
